key_load_ctrl: RTL
==================

Name: key_load_ctrl

Overview:
Sequencer between the microprocessor byte interface and the 32x8 key RAM in the modchip path. It accepts a multi-byte key one byte at a time and writes each byte to consecutive RAM addresses. It then reads the bytes back and compares them against the expected key, and drives the HaHa board LEDs with the verdict. Repeated failures lock the block until reset.

Parameters:
KEY_LEN, 4, number of key bytes per attempt (1..32); RAM addresses 0..KEY_LEN-1 are used.
KEY_VALUE, 32'h00C0FFEE, expected key, 8*KEY_LEN bits; byte i = KEY_VALUE[8i+7:8i]; byte 0 is sent first.
RD_LAT, 1, RAM read latency in clocks, from address presented to q valid (1 or 2).
MAX_FAIL, 3, consecutive failed attempts that cause lockout (1..15).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
up_din  input  8  key byte from microprocessor
up_valid  input  1  up_din valid this cycle
up_ready  output  1  block can accept a byte; transfer occurs when up_valid & up_ready
up_abort  input  1  synchronous: discard the partial attempt and return to IDLE
ram_addr  output  5  RAM address
ram_data  output  8  RAM write data
ram_wren  output  1  RAM write enable
ram_q  input  8  RAM read data
led_out  output  8  8'h00 none/reset, 8'h0F pass (green), 8'hF0 fail (red), 8'hFF locked
busy  output  1  high in LOAD, RD and WT states
fail_cnt  output  4  consecutive failure count

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; led_out=8'h00; fail_cnt=0; idx=0; mismatch=0.
  - ram_wren=0; ram_addr=0; ram_data=0; up_ready=1; busy=0.
- States: IDLE, LOAD, RD, WT, DONE, LOCKED.
- IDLE/DONE:
  - up_ready=1.
  - A transfer writes up_din to address 0: ram_wren=1, ram_addr=0, ram_data=up_din, driven combinationally in the transfer cycle.
  - Then idx=1 and mismatch clears.
  - If KEY_LEN==1, go to RD; otherwise go to LOAD.
- LOAD:
  - up_ready=1.
  - Each transfer writes address idx and increments idx.
  - The transfer at idx==KEY_LEN-1 sets idx=0 and goes to RD.
  - Idle cycles with up_valid=0 are allowed; there is no timeout.
- RD:
  - up_ready=0; ram_addr=idx; ram_wren=0.
  - Next cycle goes to WT, with a counter loaded to RD_LAT-1.
- WT:
  - ram_addr stays at idx; the counter decrements.
  - When the counter is 0, ram_q is sampled and mismatch |= (ram_q != key byte idx).
  - If idx==KEY_LEN-1, the verdict is registered on the next edge; otherwise idx++ and go to RD.
- Latency: each byte takes RD_LAT+1 cycles. led_out updates KEY_LEN*(RD_LAT+1)+1 cycles after the edge that accepted the last byte.
- Verdict:
  - mismatch=0: led_out=8'h0F; fail_cnt=0; go to DONE.
  - mismatch=1: fail_cnt++. If the new count equals MAX_FAIL, go to LOCKED with led_out=8'hFF; otherwise led_out=8'hF0 and go to DONE.
- led_out holds its previous verdict through a new attempt until the new verdict is registered.
- LOCKED:
  - up_ready=0; ram_wren=0; up_abort is ignored.
  - Exit only via rst_n.
- up_abort:
  - In LOAD, RD or WT it takes priority over a same-cycle transfer: no write, idx=0, go to IDLE.
  - led_out and fail_cnt are unchanged; no failure is counted.
  - In IDLE/DONE it blocks the transfer that cycle.
- ram_wren is high only in transfer cycles and never when up_ready=0.
- fail_cnt saturates at MAX_FAIL.
- Reset mid-attempt: all state returns to reset values. RAM contents are not cleared.

Decomposition:
- Shared package key_pkg holds:
  - state encoding typedef: 3-bit enum for IDLE/LOAD/RD/WT/DONE/LOCKED;
  - LED constants LED_OFF=8'h00, LED_PASS=8'h0F, LED_FAIL=8'hF0, LED_LOCK=8'hFF;
  - RAM_AW=5.
- No sub-module; a single FSM with an index counter and a wait counter.
- The RAM stays instantiated by the parent top.

Test Plan:
1. Reset, then send EE,FF,C0,00 with valid held high, RD_LAT=1 -> ram writes at addresses 0..3; led_out=8'h0F exactly 9 cycles after the last accept; fail_cnt=0.
2. Send EE,FF,C1,00 -> led_out=8'hF0, fail_cnt=1; then send the correct key -> led_out=8'h0F, fail_cnt=0.
3. Three wrong attempts -> after the third, led_out=8'hFF and up_ready=0; further up_valid causes no ram_wren; drop rst_n -> led_out=8'h00 immediately and up_ready=1.
4. Send EE,FF, then assert up_abort together with up_valid carrying C0 -> no write to address 2, state IDLE; a new correct key then passes; fail_cnt unchanged.
5. Insert random up_valid gaps between bytes and set RD_LAT=2 -> same pass verdict; latency 13 cycles after the last accept; up_ready=0 for the whole read-back.
6. Assert rst_n low during WT of byte 1 -> outputs return to reset values asynchronously; the next correct attempt passes.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the key load/verify sequencer.
package key_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD,
    S_WT,
    S_DONE,
    S_LOCKED
  } state_t;

  localparam logic [7:0] LED_OFF  = 8'h00;
  localparam logic [7:0] LED_PASS = 8'h0F;
  localparam logic [7:0] LED_FAIL = 8'hF0;
  localparam logic [7:0] LED_LOCK = 8'hFF;

  localparam int RAM_AW = 5;

endpackage

// File: rtl/key_load_ctrl.sv
// Loads a key byte-wise into the key RAM, reads it back, compares,
// and shows the verdict on the LEDs; locks after repeated failures.
module key_load_ctrl
  import key_pkg::*;
#(
  parameter int                    KEY_LEN   = 4,
  parameter logic [8*KEY_LEN-1:0]  KEY_VALUE = 32'h00C0FFEE,
  parameter int                    RD_LAT    = 1,
  parameter int                    MAX_FAIL  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        up_din,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic              up_abort,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  output logic [7:0]        led_out,
  output logic              busy,
  output logic [3:0]        fail_cnt
);

  localparam logic [RAM_AW-1:0] LAST = RAM_AW'(KEY_LEN - 1);
  localparam logic [1:0]        CNT0 = 2'(RD_LAT - 1);
  localparam logic [3:0]        MAXF = 4'(MAX_FAIL);

  state_t              st_q, st_d;
  logic [RAM_AW-1:0]   idx_q, idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                mis_q, mis_d;
  logic                vld_q, vld_d;
  logic [7:0]          led_q, led_d;
  logic [3:0]          fcnt_q, fcnt_d;

  logic                xfer;
  logic [8*KEY_LEN-1:0] key_sh;
  logic [7:0]          key_b;

  assign up_ready = (st_q == S_IDLE) || (st_q == S_DONE) ||
                    (st_q == S_LOAD);
  assign busy     = (st_q == S_LOAD) || (st_q == S_RD) ||
                    (st_q == S_WT);
  assign xfer     = up_valid & up_ready & ~up_abort;

  assign ram_wren = xfer;
  assign ram_addr = idx_q;
  assign ram_data = xfer ? up_din : 8'h00;
  assign led_out  = led_q;
  assign fail_cnt = fcnt_q;

  assign key_sh = KEY_VALUE >> {idx_q, 3'b000};
  assign key_b  = key_sh[7:0];

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    mis_d  = mis_q;
    vld_d  = vld_q;
    led_d  = led_q;
    fcnt_d = fcnt_q;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        if (xfer) begin
          mis_d = 1'b0;
          if (KEY_LEN == 1) begin
            idx_d = '0;
            st_d  = S_RD;
          end else begin
            idx_d = RAM_AW'(1);
            st_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (up_abort) begin
          idx_d = '0;
          st_d  = S_IDLE;
        end else if (xfer) begin
          if (idx_q == LAST) begin
            idx_d = '0;
            st_d  = S_RD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RD: begin
        if (up_abort) begin
          idx_d = '0;
          st_d  = S_IDLE;
        end else begin
          cnt_d = CNT0;
          vld_d = 1'b0;
          st_d  = S_WT;
        end
      end
      S_WT: begin
        if (up_abort) begin
          idx_d = '0;
          vld_d = 1'b0;
          st_d  = S_IDLE;
        end else if (vld_q) begin
          // last byte compared: register the verdict
          vld_d = 1'b0;
          idx_d = '0;
          if (!mis_q) begin
            led_d  = LED_PASS;
            fcnt_d = '0;
            st_d   = S_DONE;
          end else begin
            if (fcnt_q != MAXF) fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q + 4'd1 == MAXF) begin
              led_d = LED_LOCK;
              st_d  = S_LOCKED;
            end else begin
              led_d = LED_FAIL;
              st_d  = S_DONE;
            end
          end
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mis_d = mis_q | (ram_q != key_b);
          if (idx_q == LAST) begin
            vld_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            st_d  = S_RD;
          end
        end
      end
      S_LOCKED: ;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      idx_q  <= '0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
      vld_q  <= 1'b0;
      led_q  <= LED_OFF;
      fcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      mis_q  <= mis_d;
      vld_q  <= vld_d;
      led_q  <= led_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule
